sens_frame_writer: RTL and testbench
====================================

Name: sens_frame_writer

Overview:
- Producer side of the ToF sensor frame buffer. Collects per-zone distance samples arriving from the sensor I2C/readout engines over a valid/ready stream.
- Writes each sample into the shared 512-entry sensor data buffer at address {sensor, row, col}.
- Raises drdy once every zone of every sensor is captured, then holds the frame until the downstream surface/AXI read FSM acknowledges it.

Parameters:
- NUM_SENS, 8, sensors per frame; legal range 1..8; sensor index is always 3 bits.
- DATA_W, 16, width of one zone distance sample.
- TIMEOUT_CYC, 1000000, partial-frame timeout in clk cycles (used only with FRAME_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_sens  in  3  sensor index
- s_zone  in  6  zone index; row = s_zone[5:3], col = s_zone[2:0]
- s_data  in  DATA_W  distance sample
- wr_en  out  1  buffer write strobe
- wr_addr  out  9  buffer address {sens, row, col}
- wr_data  out  DATA_W  buffer write data
- drdy  out  1  complete frame in buffer
- frame_ack  in  1  single-cycle pulse from the reader: frame consumed
- sens_done  out  NUM_SENS  bit i set when all 64 zones of sensor i are captured
- err_pulse  out  1  one-cycle pulse on a duplicate zone or an out-of-range sensor
- frame_cnt  out  8  completed frame counter
- timeout  out  1  one-cycle pulse on partial-frame abort

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All outputs reset to 0: s_ready, wr_en, wr_addr, wr_data, drdy, sens_done, err_pulse, frame_cnt, timeout.
  - State returns to COLLECT. Zone bitmap (NUM_SENS x 64 bits), per-sensor counters (7 bits) and the timeout counter are cleared.
- States: COLLECT and FRAME_READY.
- s_ready:
  - Equals 1 in COLLECT and 0 in FRAME_READY.
  - Registered, so it goes low the cycle after the final sample is accepted.
  - A sample presented in the same cycle as the final sample cannot be accepted.
- Accepted sample with s_sens < NUM_SENS:
  - Next cycle: wr_en=1, wr_addr={s_sens,s_zone}, wr_data=s_data. Latency is 1 cycle.
  - wr_en stays high for exactly one cycle per accepted sample, so back-to-back accepts give a continuous wr_en.
- Duplicate zone (bitmap bit already set in this frame):
  - The sample is still written, overwriting the old value.
  - The counter is not incremented.
  - err_pulse=1 in the write cycle.
- s_sens >= NUM_SENS:
  - The sample is accepted and dropped: no write.
  - err_pulse=1 in the following cycle.
- Counter reaching 64: sets sens_done[s_sens] in the write cycle.
- Frame completion:
  - Trigger: the accept that completes the last missing zone, i.e. all sens_done bits would be set.
  - Next cycle: state=FRAME_READY, drdy=1 (same cycle as that final wr_en), frame_cnt+1 (wraps 255->0).
- FRAME_READY:
  - drdy held at 1 and s_ready held at 0.
  - On frame_ack=1: next cycle drdy=0, state=COLLECT, s_ready=1, bitmap/counters/sens_done cleared.
- frame_ack received in COLLECT is ignored.
- rst mid-frame: partial data stays in the buffer but is treated as absent; the next frame starts from zero. No wr_en occurs in the cycle after rst.

Optional Feature:
FRAME_TIMEOUT_EN:
- Defined:
  - A 20-bit (or $clog2(TIMEOUT_CYC)) counter starts on the first accepted sample of a frame and increments each COLLECT cycle.
  - On reaching TIMEOUT_CYC with the frame incomplete, the partial frame is aborted:
    - bitmap, counters and sens_done cleared;
    - timeout=1 for one cycle;
    - no drdy and no frame_cnt change.
  - A sample accepted in the abort cycle counts as the first sample of the new frame.
  - The counter does not run in FRAME_READY.
- Undefined:
  - No counter; a partial frame persists indefinitely.
  - timeout is tied to 0.

Test Plan:
- Full frame, NUM_SENS=8: 512 samples in sensor/zone order with s_valid held high -> 512 consecutive wr_en pulses, addresses 0..511 with wr_data matching; drdy=1 on the cycle of the 512th wr_en; s_ready=0; frame_cnt=1.
- Ack: hold frame_ack=0 for 20 cycles, then pulse it -> drdy stays 1 for those cycles, drops the cycle after the ack; s_ready=1; sens_done=0; a second frame increments frame_cnt to 2.
- Duplicate and out-of-range: NUM_SENS=4, send zone (2,37) twice and one sample with s_sens=5 -> two writes to 0x0A5 (second value kept), err_pulse twice, no write for sensor 5, sens_done[2] still 0 after 63 unique zones.
- Interleaved sensors: zones in reverse order, sensors round-robin -> drdy only after the last unique zone; sens_done bits set individually as each reaches 64.
- Reset mid-frame: rst after 300 samples, then a full frame -> drdy only after 512 new unique samples; frame_cnt=1.
- FRAME_TIMEOUT_EN, TIMEOUT_CYC=100: 10 samples, then idle -> timeout pulse 100 cycles after the first accept; sens_done=0; no drdy.

Source files
------------

// File: rtl/sens_frame_writer.sv
// Producer side of the ToF frame buffer: writes zone samples to {sens,row,col} and flags full frames.
// Define FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC cycles.
module sens_frame_writer #(
  parameter int unsigned NUM_SENS    = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2:0]          s_sens,
  input  logic [5:0]          s_zone,
  input  logic [DATA_W-1:0]   s_data,
  output logic                wr_en,
  output logic [8:0]          wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                drdy,
  input  logic                frame_ack,
  output logic [NUM_SENS-1:0] sens_done,
  output logic                err_pulse,
  output logic [7:0]          frame_cnt,
  output logic                timeout
);

  localparam int unsigned SW = (NUM_SENS > 1) ? $clog2(NUM_SENS) : 1;
  localparam int unsigned BW = NUM_SENS * 64;

  if ((NUM_SENS < 1) || (NUM_SENS > 8) || (TIMEOUT_CYC < 2)) begin : g_bad_params
    $error("sens_frame_writer: NUM_SENS must be 1..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic {StCollect, StFrameReady} state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       bitmap_q, bitmap_d;
  logic [6:0]          cnt_q [NUM_SENS];
  logic [6:0]          cnt_d [NUM_SENS];
  logic [NUM_SENS-1:0] done_q, done_d;
  logic                s_ready_q, s_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [8:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                drdy_q, drdy_d;
  logic                err_q, err_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  logic                accept;
  logic                in_range;
  logic [SW-1:0]       sens_idx;
  logic [SW+5:0]       bit_idx;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          tmo_run_q, tmo_run_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  assign accept   = s_valid && s_ready_q;
  assign in_range = 32'(s_sens) < NUM_SENS;
  assign sens_idx = s_sens[SW-1:0];
  assign bit_idx  = {sens_idx, s_zone};

  always_comb begin
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    drdy_d      = drdy_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
`ifdef FRAME_TIMEOUT_EN
    tmo_run_d   = tmo_run_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = 1'b0;
`endif

    unique case (state_q)
      StCollect: begin
`ifdef FRAME_TIMEOUT_EN
        if (tmo_run_q) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_q == TW'(TIMEOUT_CYC)) begin
            bitmap_d  = '0;
            cnt_d     = '{default: '0};
            done_d    = '0;
            timeout_d = 1'b1;
            tmo_run_d = 1'b0;
            tmo_cnt_d = '0;
          end
        end
        // An accept in the abort cycle restarts the timer as a fresh frame.
        if (accept && !tmo_run_d) begin
          tmo_run_d = 1'b1;
          tmo_cnt_d = TW'(1);
        end
`endif
        if (accept) begin
          if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {s_sens, s_zone};
            wr_data_d = s_data;
            if (bitmap_d[bit_idx]) begin
              err_d = 1'b1;
            end else begin
              bitmap_d[bit_idx] = 1'b1;
              cnt_d[sens_idx]   = cnt_d[sens_idx] + 7'd1;
              if (cnt_d[sens_idx] == 7'd64) begin
                done_d[sens_idx] = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
        if (&done_d) begin
          state_d     = StFrameReady;
          drdy_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
`ifdef FRAME_TIMEOUT_EN
          tmo_run_d   = 1'b0;
          tmo_cnt_d   = '0;
`endif
        end
      end
      StFrameReady: begin
        if (frame_ack) begin
          state_d  = StCollect;
          drdy_d   = 1'b0;
          bitmap_d = '0;
          cnt_d    = '{default: '0};
          done_d   = '0;
        end
      end
      default: state_d = StCollect;
    endcase

    s_ready_d = (state_d == StCollect);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      bitmap_q    <= '0;
      cnt_q       <= '{default: '0};
      done_q      <= '0;
      s_ready_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      drdy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FRAME_TIMEOUT_EN
      tmo_run_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      s_ready_q   <= s_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      drdy_q      <= drdy_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_TIMEOUT_EN
      tmo_run_q   <= tmo_run_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign drdy      = drdy_q;
  assign sens_done = done_q;
  assign err_pulse = err_q;
  assign frame_cnt = frame_cnt_q;
`ifdef FRAME_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sens_frame_writer.sv
// Directed bench for sens_frame_writer: 8-sensor, 4-sensor and short-timeout instances share stimulus.
module tb_sens_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [2:0]  s_sens;
  logic [5:0]  s_zone;
  logic [15:0] s_data;
  logic        frame_ack;

  always #5 clk = ~clk;

  // 8-sensor instance
  logic a_ready, a_wr_en, a_drdy, a_err, a_tmo;
  logic [8:0] a_addr;
  logic [15:0] a_data;
  logic [7:0] a_done, a_fcnt;
  // 4-sensor instance
  logic b_ready, b_wr_en, b_drdy, b_err, b_tmo;
  logic [8:0] b_addr;
  logic [15:0] b_data;
  logic [3:0] b_done;
  logic [7:0] b_fcnt;
  // 8-sensor instance with a 100-cycle timeout
  logic c_ready, c_wr_en, c_drdy, c_err, c_tmo;
  logic [8:0] c_addr;
  logic [15:0] c_data;
  logic [7:0] c_done, c_fcnt;

  sens_frame_writer #(.NUM_SENS(8), .DATA_W(16), .TIMEOUT_CYC(1000000)) u_dut8 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_ready), .s_sens(s_sens),
    .s_zone(s_zone), .s_data(s_data), .wr_en(a_wr_en), .wr_addr(a_addr), .wr_data(a_data),
    .drdy(a_drdy), .frame_ack(frame_ack), .sens_done(a_done), .err_pulse(a_err),
    .frame_cnt(a_fcnt), .timeout(a_tmo)
  );

  sens_frame_writer #(.NUM_SENS(4), .DATA_W(16), .TIMEOUT_CYC(5000)) u_dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_ready), .s_sens(s_sens),
    .s_zone(s_zone), .s_data(s_data), .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_data),
    .drdy(b_drdy), .frame_ack(frame_ack), .sens_done(b_done), .err_pulse(b_err),
    .frame_cnt(b_fcnt), .timeout(b_tmo)
  );

  sens_frame_writer #(.NUM_SENS(8), .DATA_W(16), .TIMEOUT_CYC(100)) u_dut_tmo (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(c_ready), .s_sens(s_sens),
    .s_zone(s_zone), .s_data(s_data), .wr_en(c_wr_en), .wr_addr(c_addr), .wr_data(c_data),
    .drdy(c_drdy), .frame_ack(frame_ack), .sens_done(c_done), .err_pulse(c_err),
    .frame_cnt(c_fcnt), .timeout(c_tmo)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] data_of(input int i);
    return 16'((i * 37) ^ 32'h5A00);
  endfunction

  task automatic send(input logic [2:0] sn, input logic [5:0] zn, input logic [15:0] d);
    s_valid = 1'b1;
    s_sens  = sn;
    s_zone  = zn;
    s_data  = d;
    tick();
  endtask

  task automatic do_reset();
    s_valid   = 1'b0;
    frame_ack = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Sensor/zone order on the 8-sensor instance; drdy expected only with sample 511.
  task automatic stream_frame(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      send(3'(i >> 6), 6'(i & 63), data_of(i));
      if (a_wr_en !== 1'b1 || a_addr !== 9'(i) || a_data !== data_of(i) ||
          a_drdy !== (i == 511)) bad++;
    end
  endtask

  initial begin
    int bad;
    int tmo_seen;
    logic [7:0] exp_done;
    s_valid = 1'b0; s_sens = '0; s_zone = '0; s_data = '0; frame_ack = 1'b0; rst = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_wr_en", 32'(a_wr_en), 32'd0);
    check("rst_addr_data", {7'd0, a_addr, a_data}, 32'd0);
    check("rst_drdy_err_tmo", {29'd0, a_drdy, a_err, a_tmo}, 32'd0);
    check("rst_done_fcnt", {16'd0, a_done, a_fcnt}, 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(a_ready), 32'd1);

    // Full frame in sensor/zone order with s_valid held high
    stream_frame(512, bad);
    check("frame1_stream", 32'(bad), 32'd0);
    check("frame1_ready_low", 32'(a_ready), 32'd0);
    check("frame1_fcnt", 32'(a_fcnt), 32'd1);
    check("frame1_done", 32'(a_done), 32'hFF);
    s_data = 16'hDEAD;
    tick();
    check("frame1_no_extra_write", 32'(a_wr_en), 32'd0);
    check("frame1_drdy_hold", 32'(a_drdy), 32'd1);

    // Ack: drdy held until the pulse, drops the cycle after
    s_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_drdy !== 1'b1 || a_ready !== 1'b0) bad++;
    end
    check("ack_wait_hold", 32'(bad), 32'd0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("ack_drdy_low", 32'(a_drdy), 32'd0);
    check("ack_ready_high", 32'(a_ready), 32'd1);
    check("ack_done_clear", 32'(a_done), 32'd0);

    stream_frame(512, bad);
    check("frame2_stream", 32'(bad), 32'd0);
    check("frame2_fcnt", 32'(a_fcnt), 32'd2);
    s_valid = 1'b0;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("ack_in_collect_ignored", {22'd0, a_drdy, a_ready, a_fcnt}, {22'd0, 1'b0, 1'b1, 8'd2});

    // Duplicate and out-of-range on the 4-sensor instance
    do_reset();
    send(3'd2, 6'd37, 16'h1111);
    check("dup_first_write", {6'd0, b_wr_en, b_addr, b_data}, {6'd0, 1'b1, 9'h0A5, 16'h1111});
    check("dup_first_err", 32'(b_err), 32'd0);
    send(3'd2, 6'd37, 16'h2222);
    check("dup_second_write", {6'd0, b_wr_en, b_addr, b_data}, {6'd0, 1'b1, 9'h0A5, 16'h2222});
    check("dup_second_err", 32'(b_err), 32'd1);
    send(3'd5, 6'd0, 16'h3333);
    check("oor_no_write", 32'(b_wr_en), 32'd0);
    check("oor_err", 32'(b_err), 32'd1);
    bad = 0;
    for (int z = 0; z < 63; z++) begin
      if (z != 37) begin
        send(3'd2, 6'(z), 16'(z));
        if (b_err !== 1'b0 || b_wr_en !== 1'b1) bad++;
      end
    end
    check("dup_unique_fill", 32'(bad), 32'd0);
    check("dup_63_not_done", 32'(b_done), 32'd0);
    send(3'd2, 6'd63, 16'h0063);
    check("dup_64_done", 32'(b_done), 32'h4);
    check("dup_no_drdy", 32'(b_drdy), 32'd0);

    // Interleaved sensors, zones in reverse order
    do_reset();
    bad = 0;
    for (int z = 63; z >= 0; z--) begin
      for (int s = 0; s < 8; s++) begin
        send(3'(s), 6'(z), data_of(s * 64 + z));
        exp_done = (z == 0) ? 8'((1 << (s + 1)) - 1) : 8'h00;
        if (a_wr_en !== 1'b1 || a_addr !== 9'(s * 64 + z) || a_data !== data_of(s * 64 + z) ||
            a_done !== exp_done || a_drdy !== (z == 0 && s == 7)) bad++;
      end
    end
    check("ileave_stream", 32'(bad), 32'd0);
    check("ileave_fcnt", 32'(a_fcnt), 32'd1);

    // Reset mid-frame
    do_reset();
    stream_frame(300, bad);
    check("partial_stream", 32'(bad), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_data = 16'hBEEF;
    tick();
    check("post_rst_no_write", 32'(a_wr_en), 32'd0);
    check("post_rst_state", {22'd0, a_ready, a_drdy, a_done}, {22'd0, 1'b1, 1'b0, 8'h00});
    stream_frame(512, bad);
    check("after_rst_stream", 32'(bad), 32'd0);
    check("after_rst_fcnt", 32'(a_fcnt), 32'd1);

    // Partial frame then idle on the short-timeout instance
    do_reset();
    for (int i = 0; i < 10; i++) send(3'd0, 6'(i), 16'(i));
    s_valid = 1'b0;
    tmo_seen = 0;
    bad = 0;
    for (int k = 10; k <= 101; k++) begin
      tick();
      if (c_tmo === 1'b1) begin
        tmo_seen++;
        if (k != 100) bad++;
      end
    end
`ifdef FRAME_TIMEOUT_EN
    check("tmo_pulse_count", 32'(tmo_seen), 32'd1);
    check("tmo_pulse_timing", 32'(bad), 32'd0);
`else
    check("tmo_never", 32'(tmo_seen), 32'd0);
`endif
    check("tmo_done_drdy", {23'd0, c_drdy, c_done}, 32'd0);
    check("tmo_fcnt", 32'(c_fcnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
